serial_carry_adder: RTL and testbench

Bit-serial, handshaked WIDTH-bit adder: the responding end of the stimulus/check interface {a, b, cin} -> {cout, sum}.
- It accepts one operand set, resolves one bit per clock through a single full-adder cell, and returns {cout, sum} under valid/ready.
- It is the sequential DUT counterpart for the team's exhaustive-testing harness.
- The same harness must be able to sweep all 2^(2*WIDTH+1) inputs through it.

---
 rtl/adder_pkg.sv | 14 +
 rtl/full_adder_cell.sv | 16 +
 rtl/serial_carry_adder.sv | 123 ++++++++++++
 tb/tb_serial_carry_adder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder and its exhaustive-test harness.
package adder_pkg;

  // Default operand width; the harness sizes its sweep as 2**(2*WIDTH+1).
  localparam int unsigned DEFAULT_WIDTH = 4;

  // Controller states; encodings kept identical to the original constants.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder: the single arithmetic cell of the serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
  end

endmodule

// File: rtl/serial_carry_adder.sv
// Bit-serial WIDTH-bit adder with valid/ready handshakes on both sides.
// One operand bit pair is resolved per clock through a single full-adder cell.
module serial_carry_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic               ra_bit, rb_bit;
  logic               fa_s, fa_co;

  // Select the operand bits at the current index (loop keeps the index width independent of WIDTH).
  always_comb begin
    ra_bit = 1'b0;
    rb_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (idx_q == CNT_W'(i)) begin
        ra_bit = ra_q[i];
        rb_bit = rb_q[i];
      end
    end
  end

  full_adder_cell u_fa (
    .x  (ra_bit),
    .y  (rb_bit),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        carry_d = fa_co;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (idx_q == CNT_W'(i)) sum_d[i] = fa_s;
        end
        // The index parks on the last bit rather than wrapping past WIDTH-1.
        if (idx_q == LAST_IDX) begin
          cout_d  = fa_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_carry_adder.sv
// Directed and exhaustive self-checking bench for serial_carry_adder.
module tb_serial_carry_adder;
  import adder_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;

  serial_carry_adder #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_val(tag, 32'(in_ready), 32'd1);
  endtask

  // One handshaked add with latency check and immediate output transfer.
  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W:0] exp);
    wait_ready({tag, "_rdy"});
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_val({tag, "_busy"}, 32'(in_ready), 32'd0);
    repeat (W - 1) tick();
    check_val({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_res"}, 32'({cout, sum}), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xfers;
    int n;
    logic [8:0] vv;
    logic [W:0] exp;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    @(negedge clk);

    // Reset and idle
    repeat (2) tick();
    check_val("rst_hs", 32'({in_ready, out_valid}), 32'b10);
    check_val("rst_res", 32'({cout, sum}), 32'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    check_val("idle_hs", 32'({in_ready, out_valid}), 32'b10);
    check_val("idle_res", 32'({cout, sum}), 32'h0);

    // Directed additions (expected values hand-computed)
    run_add("basic", 4'hA, 4'h5, 1'b0, 5'h0F);
    run_add("chain", 4'hF, 4'h0, 1'b1, 5'h10);
    run_add("allones", 4'hF, 4'hF, 1'b1, 5'h1F);
    run_add("zero", 4'h0, 4'h0, 1'b0, 5'h00);

    // Backpressure: result held while out_ready is low, input activity ignored
    wait_ready("bp_rdy");
    a = 4'h7; b = 4'h9; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      a = 4'(i * 3 + 1);
      b = 4'(i + 5);
      cin = i[1];
      tick();
      check_val("bp_valid", 32'(out_valid), 32'd1);
      check_val("bp_busy", 32'(in_ready), 32'd0);
      check_val("bp_res", 32'({cout, sum}), 32'h10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("bp_release", 32'({in_ready, out_valid}), 32'b10);

    // Reset during the second ADD cycle discards the result
    a = 4'h3; b = 4'h3; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_val("midrst_hs", 32'({in_ready, out_valid}), 32'b10);
    check_val("midrst_res", 32'({cout, sum}), 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) n++;
    end
    out_ready = 1'b0;
    check_val("midrst_never", 32'(n), 32'd0);

    // Exhaustive sweep with in_valid and out_ready held high
    xfers = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int v = 0; v < 512; v++) begin
      vv = v[8:0];
      wait_ready("sweep_rdy");
      a = vv[8:5]; b = vv[4:1]; cin = vv[0];
      exp = (W+1)'(int'(vv[8:5]) + int'(vv[4:1]) + int'(vv[0]));
      tick();
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check_val("sweep_res", 32'({out_valid, cout, sum}), 32'({1'b1, exp}));
      if (out_valid) xfers++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_val("sweep_xfers", 32'(xfers), 32'd512);
    tick();
    check_val("sweep_end", 32'({in_ready, out_valid}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
